divisor_radix_param: RTL and testbench
======================================

# divisor_radix_param

- Parametrised multi-cycle restoring integer divider, successor to the team's fixed 32-bit, 1-bit-per-two-cycles divider.
- Retires `BPC` quotient bits per clock.
- Handles signed and unsigned operands, selected per operation.
- Flags divide-by-zero and exposes a `Busy` status.
- Sits on a datapath next to the ALU and is driven through a `Start`/`Done` handshake by a control FSM.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width; must be a multiple of `BPC` and ≥ 4.
- `BPC`, default 1: quotient bits retired per iteration cycle; legal values 1, 2, 4.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  reset: synchronous and active-high.
- `Start`  in  1  request; sampled only in `IDLE`.
- `Signed`  in  1  1 = two's-complement operands; 0 = unsigned; sampled with `Start`.
- `Num`  in  `WIDTH`  dividend; sampled with `Start`.
- `Den`  in  `WIDTH`  divisor; sampled with `Start`.
- `Coc`  out  `WIDTH`  quotient, registered.
- `Res`  out  `WIDTH`  remainder, registered.
- `DivZero`  out  1  registered; qualifies the current `Coc`/`Res`.
- `Busy`  out  1  high while an operation is in flight.
- `Done`  out  1  one-cycle pulse; `Coc`/`Res`/`DivZero` valid.

## Operation
- States: `IDLE`, `ITER`, `FIX`.
- `IDLE` with `Start`=1, divisor non-zero:
  - latch sign flags: `SignNum`=`Num[MSB]`&`Signed`, `SignDen`=`Den[MSB]`&`Signed`;
  - load magnitudes into `Q` and `M`;
  - clear `ACCU`; set `CONT`=`WIDTH/BPC`−1; go to `ITER`.
- `IDLE` with `Start`=1, `Den`=0: set the zero flag and go straight to `FIX`, skipping `ITER`.
- `ITER`: each cycle performs `BPC` restoring steps (shift `{ACCU,Q}` left 1, compare/subtract `M`, set `Q` LSB), then decrements `CONT`. When `CONT`=0, go to `FIX`.
- `FIX`, normal case:
  - `Coc` = −`Q` if `SignNum`^`SignDen`, else `Q`;
  - `Res` = −`ACCU` if `SignNum`, else `ACCU`;
  - `DivZero`=0; `Done`=1; go to `IDLE`.
  - Signed results truncate toward zero; the remainder takes the dividend's sign.
- `FIX`, divide-by-zero case: `Coc`=all ones; `Res`=`Num` as latched; `DivZero`=1.
- Signed overflow (most-negative ÷ −1): `Coc` wraps to the most-negative value, `Res`=0. No flag.
- `Start` outside `IDLE` is ignored. Operands are not re-sampled mid-operation.
- `Coc`/`Res`/`DivZero` hold their values until the next `FIX`.

## Timing
- `Start` is accepted at edge 0. `ITER` occupies edges 1..`WIDTH/BPC`. `FIX` is at edge `WIDTH/BPC`+1, where `Done` rises for exactly one cycle.
- Latency from `Start` to `Done`:
  - `WIDTH/BPC`+1 cycles;
  - 33 for 32/1; 17 for 32/2; 9 for 32/4;
  - divide-by-zero: 1 cycle.
- `Busy` is 1 from the edge after `Start` until the `FIX` edge, inclusive. It is 0 in the `Done` cycle.
- The `Done` cycle is in `IDLE`, so `Start` may be reasserted in that same cycle (back-to-back). Throughput is one result per `WIDTH/BPC`+1 cycles.
- `RST` takes priority in every state. Reset mid-operation aborts the operation with no `Done`. Reset values:
  - state=`IDLE`;
  - `Coc`=0, `Res`=0, `DivZero`=0, `Busy`=0, `Done`=0;
  - internal `ACCU`/`Q`/`M`/`CONT`/sign flags=0.
- `CONT` width is `$clog2(WIDTH/BPC)`, minimum 1 bit.

## Structure
- Shared package `divisor_pkg`:
  - state enum `div_state_t` {`IDLE`,`ITER`,`FIX`};
  - functions `abs_val` and `neg2c`, parametrised by width.
- One sub-module, `div_restoring_step`: a combinational chain of `BPC` shift/compare/subtract stages. Inputs `ACCU`, `Q`, `M`; outputs next `ACCU` and next `Q`.
- Top level holds the FSM, counter, sign handling and output registers.

## Test plan
- `WIDTH`=32, `BPC`=1, `Signed`=0, 100/7 → `Coc`=14, `Res`=2, `DivZero`=0; `Done` 33 cycles after `Start`; `Busy` high for 32 cycles.
- `Signed`=1: −100/7 → `Coc`=−14, `Res`=−2. 100/−7 → −14, 2. −100/−7 → 14, −2.
- `Den`=0, `Num`=0x1234 → `Done` after 1 cycle; `Coc`=0xFFFFFFFF, `Res`=0x1234, `DivZero`=1. Next valid divide clears `DivZero`.
- `WIDTH`=8, `BPC`=4, `Signed`=1, −128/−1 → `Coc`=0x80, `Res`=0; `Done` after 3 cycles. Unsigned 255/16 → 15, 15.
- Back-to-back `Start` in the `Done` cycle → second result correct; `Start` pulsed mid-`ITER` → ignored, first result unchanged.
- `RST` at iteration 10 → outputs zero next cycle, no `Done`. A new `Start` afterwards completes with normal latency.
- Random signed/unsigned sweep for each `BPC` in {1,2,4} against a reference model, checking `Coc`·`Den`+`Res`=`Num` and |`Res`|<|`Den`|.

Source files
------------

// File: rtl/divisor_pkg.sv
// Shared types and helpers for the radix-parametrised restoring divider.
// Contents: FSM state enum, two's-complement negate and magnitude helpers.
// The helpers work on a MAX_W-bit container; callers zero-extend their
// operand, pass its real width, and truncate the result back.
package divisor_pkg;

   localparam int unsigned MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } div_state_t;

   // Two's-complement negate; the low w bits are correct for any w <= MAX_W.
   function automatic logic [MAX_W-1:0] neg2c(input logic [MAX_W-1:0] x);
      return (~x) + MAX_W'(1);
   endfunction

   // Magnitude of a zero-extended w-bit two's-complement value.
   function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x,
                                                input int unsigned     w);
      if (((x >> (w - 1)) & MAX_W'(1)) != '0) return neg2c(x);
      return x;
   endfunction

endpackage

// File: rtl/div_restoring_step.sv
// Combinational chain of BPC restoring-division steps.
// Ports: accu/q/m  - partial remainder, dividend/quotient shift register, divisor
//        accu_nxt/q_nxt - partial remainder and quotient after BPC steps
module div_restoring_step #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned BPC   = 1
) (
   input  logic [WIDTH-1:0] accu,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH-1:0] accu_nxt,
   output logic [WIDTH-1:0] q_nxt
);

   // One extra bit: the shifted remainder can reach 2*m-1 before the subtract.
   logic [WIDTH:0]   sh;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] qq;

   always_comb begin
      a  = accu;
      qq = q;
      sh = '0;
      for (int i = 0; i < int'(BPC); i++) begin
         sh = {a, qq[WIDTH-1]};
         qq = {qq[WIDTH-2:0], 1'b0};
         if (sh >= {1'b0, m}) begin
            sh    = sh - {1'b0, m};
            qq[0] = 1'b1;
         end
         a = sh[WIDTH-1:0];
      end
      accu_nxt = a;
      q_nxt    = qq;
   end

endmodule

// File: rtl/divisor_radix_param.sv
// Multi-cycle restoring integer divider retiring BPC quotient bits per clock,
// signed or unsigned per operation, with divide-by-zero flag.
// Ports: CLK, RST (sync, active-high); Start/Signed/Num/Den request inputs;
//        Coc (quotient), Res (remainder), DivZero, Busy, Done (1-cycle pulse).
// WIDTH must be a multiple of BPC, >= 4 and <= divisor_pkg::MAX_W.
module divisor_radix_param
   import divisor_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned BPC   = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Start,
   input  logic             Signed,
   input  logic [WIDTH-1:0] Num,
   input  logic [WIDTH-1:0] Den,
   output logic [WIDTH-1:0] Coc,
   output logic [WIDTH-1:0] Res,
   output logic             DivZero,
   output logic             Busy,
   output logic             Done
);

   localparam int unsigned N_ITER = WIDTH / BPC;
   localparam int unsigned CW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;

   div_state_t       state_q, state_d;
   logic [WIDTH-1:0] accu_q, accu_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [CW-1:0]    cont_q, cont_d;
   logic             sign_num_q, sign_num_d;
   logic             sign_den_q, sign_den_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] coc_q, coc_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             div_zero_q, div_zero_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] step_accu_c, step_q_c;
   logic [WIDTH-1:0] num_mag_c, den_mag_c;

   div_restoring_step #(
      .WIDTH (WIDTH),
      .BPC   (BPC)
   ) u_step (
      .accu     (accu_q),
      .q        (q_q),
      .m        (m_q),
      .accu_nxt (step_accu_c),
      .q_nxt    (step_q_c)
   );

   // Operand magnitudes; unsigned operands pass through untouched.
   always_comb begin
      num_mag_c = Num;
      den_mag_c = Den;
      if (Signed) begin
         num_mag_c = WIDTH'(abs_val(MAX_W'(Num), WIDTH));
         den_mag_c = WIDTH'(abs_val(MAX_W'(Den), WIDTH));
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d    = state_q;
      accu_d     = accu_q;
      q_d        = q_q;
      m_d        = m_q;
      cont_d     = cont_q;
      sign_num_d = sign_num_q;
      sign_den_d = sign_den_q;
      dz_d       = dz_q;
      coc_d      = coc_q;
      res_d      = res_q;
      div_zero_d = div_zero_q;
      busy_d     = (state_q == ITER);
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (Start) begin
               sign_num_d = Num[WIDTH-1] & Signed;
               sign_den_d = Den[WIDTH-1] & Signed;
               accu_d     = '0;
               if (Den == '0) begin
                  // Keep the raw dividend in Q; it becomes the remainder.
                  dz_d    = 1'b1;
                  q_d     = Num;
                  m_d     = '0;
                  state_d = FIX;
               end else begin
                  dz_d    = 1'b0;
                  q_d     = num_mag_c;
                  m_d     = den_mag_c;
                  cont_d  = CW'(N_ITER - 1);
                  state_d = ITER;
               end
            end
         end
         ITER: begin
            accu_d = step_accu_c;
            q_d    = step_q_c;
            cont_d = cont_q - CW'(1);
            if (cont_q == '0) state_d = FIX;
         end
         FIX: begin
            done_d  = 1'b1;
            state_d = IDLE;
            if (dz_q) begin
               coc_d      = '1;
               res_d      = q_q;
               div_zero_d = 1'b1;
            end else begin
               // Quotient truncates toward zero; remainder follows the dividend.
               coc_d      = (sign_num_q ^ sign_den_q) ? WIDTH'(neg2c(MAX_W'(q_q))) : q_q;
               res_d      = sign_num_q ? WIDTH'(neg2c(MAX_W'(accu_q))) : accu_q;
               div_zero_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         accu_q     <= '0;
         q_q        <= '0;
         m_q        <= '0;
         cont_q     <= '0;
         sign_num_q <= 1'b0;
         sign_den_q <= 1'b0;
         dz_q       <= 1'b0;
         coc_q      <= '0;
         res_q      <= '0;
         div_zero_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         accu_q     <= accu_d;
         q_q        <= q_d;
         m_q        <= m_d;
         cont_q     <= cont_d;
         sign_num_q <= sign_num_d;
         sign_den_q <= sign_den_d;
         dz_q       <= dz_d;
         coc_q      <= coc_d;
         res_q      <= res_d;
         div_zero_q <= div_zero_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign Coc     = coc_q;
   assign Res     = res_q;
   assign DivZero = div_zero_q;
   assign Busy    = busy_q;
   assign Done    = done_q;

endmodule

// File: tb/tb_divisor_radix_param.sv
// Directed and random checks of divisor_radix_param for 32/1, 32/2, 32/4 and 8/4.
module tb_divisor_radix_param;

   logic        CLK = 1'b0;
   logic        RST;
   logic [2:0]  start32;
   logic        start8;
   logic        sg;
   logic [31:0] num, den;
   logic [7:0]  num8, den8;

   logic [2:0][31:0] coc_v, res_v;
   logic [7:0]       coc8, res8;
   logic [3:0]       dz_v, busy_v, done_v;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   divisor_radix_param #(.WIDTH(32), .BPC(1)) u_d1 (
      .CLK(CLK), .RST(RST), .Start(start32[0]), .Signed(sg), .Num(num), .Den(den),
      .Coc(coc_v[0]), .Res(res_v[0]), .DivZero(dz_v[0]), .Busy(busy_v[0]), .Done(done_v[0]));
   divisor_radix_param #(.WIDTH(32), .BPC(2)) u_d2 (
      .CLK(CLK), .RST(RST), .Start(start32[1]), .Signed(sg), .Num(num), .Den(den),
      .Coc(coc_v[1]), .Res(res_v[1]), .DivZero(dz_v[1]), .Busy(busy_v[1]), .Done(done_v[1]));
   divisor_radix_param #(.WIDTH(32), .BPC(4)) u_d4 (
      .CLK(CLK), .RST(RST), .Start(start32[2]), .Signed(sg), .Num(num), .Den(den),
      .Coc(coc_v[2]), .Res(res_v[2]), .DivZero(dz_v[2]), .Busy(busy_v[2]), .Done(done_v[2]));
   divisor_radix_param #(.WIDTH(8), .BPC(4)) u_d8 (
      .CLK(CLK), .RST(RST), .Start(start8), .Signed(sg), .Num(num8), .Den(den8),
      .Coc(coc8), .Res(res8), .DivZero(dz_v[3]), .Busy(busy_v[3]), .Done(done_v[3]));

   // Drive one request on DUT sel (3 = 8-bit), count cycles to Done and Busy cycles.
   // pulse_at != 0 re-pulses Start with other operands that many cycles in.
   task automatic do_op(input int sel, input logic s, input logic [31:0] n,
                        input logic [31:0] d, input int pulse_at,
                        output logic [31:0] q, output logic [31:0] r,
                        output logic z, output int lat, output int bcnt);
      sg = s; num = n; den = d; num8 = n[7:0]; den8 = d[7:0];
      if (sel == 3) start8 = 1'b1; else start32[sel] = 1'b1;
      @(posedge CLK); #1;
      start8 = 1'b0; start32 = '0;
      lat = 0; bcnt = 0;
      while (done_v[sel] !== 1'b1 && lat < 200) begin
         if (busy_v[sel] === 1'b1) bcnt++;
         if (pulse_at != 0 && lat == pulse_at) begin
            sg = 1'b0; num = 32'd999; den = 32'd3; num8 = 8'd99; den8 = 8'd3;
            if (sel == 3) start8 = 1'b1; else start32[sel] = 1'b1;
         end else begin
            start8 = 1'b0; start32 = '0;
         end
         @(posedge CLK); #1;
         lat++;
      end
      start8 = 1'b0; start32 = '0;
      checks++;
      if (lat >= 200) begin
         errors++;
         $display("FAIL done_timeout sel=%0d waited %0d cycles", sel, lat);
      end
      q = (sel == 3) ? {24'h0, coc8} : coc_v[sel];
      r = (sel == 3) ? {24'h0, res8} : res_v[sel];
      z = dz_v[sel];
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (coc_v[i] !== 32'h0 || res_v[i] !== 32'h0) begin
            errors++;
            $display("FAIL reset_data dut%0d got coc=%h res=%h exp 0/0", i, coc_v[i], res_v[i]);
         end
      end
      checks++;
      if (dz_v !== 4'h0 || busy_v !== 4'h0 || done_v !== 4'h0 || coc8 !== 8'h0 || res8 !== 8'h0) begin
         errors++;
         $display("FAIL reset_flags got dz=%b busy=%b done=%b coc8=%h res8=%h exp zeros",
                  dz_v, busy_v, done_v, coc8, res8);
      end
      RST = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_unsigned();
      logic [31:0] q, r; logic z; int lat, bc;
      do_op(0, 1'b0, 32'd100, 32'd7, 0, q, r, z, lat, bc);
      checks++;
      if (q !== 32'd14 || r !== 32'd2 || z !== 1'b0) begin
         errors++; $display("FAIL u_100_7 got %0d/%0d z=%b exp 14/2 z=0", q, r, z);
      end
      checks++;
      if (lat != 33) begin errors++; $display("FAIL u_latency got %0d exp 33", lat); end
      checks++;
      if (bc != 32) begin errors++; $display("FAIL u_busy_cycles got %0d exp 32", bc); end
      @(posedge CLK); #1;
      checks++;
      if (done_v[0] !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b exp 0", done_v[0]); end
      do_op(0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, q, r, z, lat, bc);
      checks++;
      if (q !== 32'hFFFF_FFFF || r !== 32'h0) begin
         errors++; $display("FAIL u_max_by_1 got %h/%h exp ffffffff/0", q, r);
      end
      do_op(0, 1'b0, 32'd5, 32'd10, 0, q, r, z, lat, bc);
      checks++;
      if (q !== 32'd0 || r !== 32'd5) begin
         errors++; $display("FAIL u_small_num got %0d/%0d exp 0/5", q, r);
      end
   endtask

   task automatic test_signed();
      logic [31:0] q, r; logic z; int lat, bc;
      do_op(0, 1'b1, 32'hFFFF_FF9C, 32'd7, 0, q, r, z, lat, bc);
      checks++;
      if (q !== 32'hFFFF_FFF2 || r !== 32'hFFFF_FFFE) begin
         errors++; $display("FAIL s_m100_7 got %h/%h exp fffffff2/fffffffe", q, r);
      end
      do_op(0, 1'b1, 32'd100, 32'hFFFF_FFF9, 0, q, r, z, lat, bc);
      checks++;
      if (q !== 32'hFFFF_FFF2 || r !== 32'd2) begin
         errors++; $display("FAIL s_100_m7 got %h/%h exp fffffff2/00000002", q, r);
      end
      do_op(0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 0, q, r, z, lat, bc);
      checks++;
      if (q !== 32'd14 || r !== 32'hFFFF_FFFE) begin
         errors++; $display("FAIL s_m100_m7 got %h/%h exp 0000000e/fffffffe", q, r);
      end
      do_op(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, q, r, z, lat, bc);
      checks++;
      if (q !== 32'h8000_0000 || r !== 32'h0 || z !== 1'b0) begin
         errors++; $display("FAIL s_overflow got %h/%h z=%b exp 80000000/0 z=0", q, r, z);
      end
   endtask

   task automatic test_div_zero();
      logic [31:0] q, r; logic z; int lat, bc;
      do_op(0, 1'b0, 32'h1234, 32'h0, 0, q, r, z, lat, bc);
      checks++;
      if (q !== 32'hFFFF_FFFF || r !== 32'h1234 || z !== 1'b1) begin
         errors++; $display("FAIL dz_result got %h/%h z=%b exp ffffffff/1234 z=1", q, r, z);
      end
      checks++;
      if (lat != 1 || bc != 0) begin
         errors++; $display("FAIL dz_latency got lat=%0d busy=%0d exp 1/0", lat, bc);
      end
      do_op(0, 1'b1, 32'hFFFF_FF00, 32'h0, 0, q, r, z, lat, bc);
      checks++;
      if (q !== 32'hFFFF_FFFF || r !== 32'hFFFF_FF00 || z !== 1'b1) begin
         errors++; $display("FAIL dz_signed got %h/%h z=%b exp ffffffff/ffffff00 z=1", q, r, z);
      end
      do_op(0, 1'b0, 32'd100, 32'd7, 0, q, r, z, lat, bc);
      checks++;
      if (q !== 32'd14 || r !== 32'd2 || z !== 1'b0) begin
         errors++; $display("FAIL dz_clear got %0d/%0d z=%b exp 14/2 z=0", q, r, z);
      end
   endtask

   task automatic test_radix();
      logic [31:0] q, r; logic z; int lat, bc;
      do_op(1, 1'b0, 32'd1000, 32'd3, 0, q, r, z, lat, bc);
      checks++;
      if (q !== 32'd333 || r !== 32'd1 || lat != 17) begin
         errors++; $display("FAIL bpc2 got %0d/%0d lat=%0d exp 333/1 lat=17", q, r, lat);
      end
      do_op(2, 1'b0, 32'hDEAD_BEEF, 32'h10, 0, q, r, z, lat, bc);
      checks++;
      if (q !== 32'h0DEA_DBEE || r !== 32'hF || lat != 9) begin
         errors++; $display("FAIL bpc4 got %h/%h lat=%0d exp 0deadbee/f lat=9", q, r, lat);
      end
      do_op(2, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, q, r, z, lat, bc);
      checks++;
      if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL bpc4_signed got %h/%h exp fffffffd/ffffffff", q, r);
      end
      do_op(3, 1'b1, 32'h80, 32'hFF, 0, q, r, z, lat, bc);
      checks++;
      if (q !== 32'h80 || r !== 32'h0 || lat != 3) begin
         errors++; $display("FAIL w8_overflow got %h/%h lat=%0d exp 80/0 lat=3", q, r, lat);
      end
      do_op(3, 1'b0, 32'hFF, 32'h10, 0, q, r, z, lat, bc);
      checks++;
      if (q !== 32'd15 || r !== 32'd15) begin
         errors++; $display("FAIL w8_unsigned got %0d/%0d exp 15/15", q, r);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] q, r; logic z; int lat, bc;
      do_op(0, 1'b0, 32'd77, 32'd5, 0, q, r, z, lat, bc);
      // Called again while still in the Done cycle.
      do_op(0, 1'b0, 32'd1000, 32'd9, 0, q, r, z, lat, bc);
      checks++;
      if (q !== 32'd111 || r !== 32'd1 || lat != 33) begin
         errors++; $display("FAIL back_to_back got %0d/%0d lat=%0d exp 111/1 lat=33", q, r, lat);
      end
   endtask

   task automatic test_start_ignored();
      logic [31:0] q, r; logic z; int lat, bc;
      do_op(0, 1'b0, 32'd100, 32'd7, 5, q, r, z, lat, bc);
      checks++;
      if (q !== 32'd14 || r !== 32'd2 || lat != 33) begin
         errors++; $display("FAIL mid_start got %0d/%0d lat=%0d exp 14/2 lat=33", q, r, lat);
      end
      @(posedge CLK); #1;
      checks++;
      if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL mid_start_busy got %b exp 0", busy_v[0]); end
   endtask

   task automatic test_rst_mid();
      logic [31:0] q, r; logic z; int lat, bc, seen;
      sg = 1'b0; num = 32'd1000; den = 32'd3; start32[0] = 1'b1;
      @(posedge CLK); #1;
      start32 = '0;
      repeat (10) @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      checks++;
      if (coc_v[0] !== 32'h0 || res_v[0] !== 32'h0 || dz_v[0] !== 1'b0 ||
          busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid got coc=%h res=%h dz=%b busy=%b done=%b exp zeros",
                  coc_v[0], res_v[0], dz_v[0], busy_v[0], done_v[0]);
      end
      seen = 0;
      repeat (40) begin
         @(posedge CLK); #1;
         if (done_v[0] === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL rst_no_done got %0d pulses exp 0", seen); end
      do_op(0, 1'b0, 32'd100, 32'd7, 0, q, r, z, lat, bc);
      checks++;
      if (q !== 32'd14 || r !== 32'd2 || lat != 33) begin
         errors++; $display("FAIL rst_recover got %0d/%0d lat=%0d exp 14/2 lat=33", q, r, lat);
      end
   endtask

   task automatic test_sweep();
      logic [31:0] q, r, n, d, eq, er, recon; logic z; int lat, bc;
      longint ln, ld, lr;
      logic s;
      for (int sel = 0; sel < 3; sel++) begin
         for (int k = 0; k < 8; k++) begin
            n = $urandom;
            d = $urandom >> $urandom_range(0, 30);
            if (d == 32'h0) d = 32'd1;
            s = (k % 2) == 1;
            if (s) begin
               ln = longint'($signed(n));
               ld = longint'($signed(d));
            end else begin
               ln = longint'({32'h0, n});
               ld = longint'({32'h0, d});
            end
            eq = 32'(ln / ld);
            er = 32'(ln % ld);
            do_op(sel, s, n, d, 0, q, r, z, lat, bc);
            checks++;
            if (q !== eq || r !== er || z !== 1'b0) begin
               errors++;
               $display("FAIL sweep sel=%0d s=%b %h/%h got %h/%h z=%b exp %h/%h z=0",
                        sel, s, n, d, q, r, z, eq, er);
            end
            recon = q * d + r;
            checks++;
            if (recon !== n) begin
               errors++; $display("FAIL sweep_identity sel=%0d got %h exp %h", sel, recon, n);
            end
            if (s) lr = longint'($signed(r)); else lr = longint'({32'h0, r});
            if (lr < 0) lr = -lr;
            if (ld < 0) ld = -ld;
            checks++;
            if (!(lr < ld)) begin
               errors++; $display("FAIL sweep_rem_bound sel=%0d got |res|=%0d exp < %0d", sel, lr, ld);
            end
         end
      end
   endtask

   initial begin
      RST = 1'b1; start32 = '0; start8 = 1'b0; sg = 1'b0;
      num = '0; den = '0; num8 = '0; den8 = '0;
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_radix();
      test_back_to_back();
      test_start_ignored();
      test_rst_mid();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
